// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and constants for the IF/MM unified-memory arbiter.
// Imported by riscv_mem_arbiter; XLEN is the core data width.
package riscv_mem_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int STRB_W       = XLEN / 8;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_BUSY_IF = 2'b01,
        ARB_BUSY_MM = 2'b10,
        ARB_DONE    = 2'b11
    } arb_state_e;

    // One memory command exactly as presented on the o_arb_mem_* fields.
    typedef struct packed {
        logic              wr_en;
        logic [STRB_W-1:0] strb;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wr_data;
    } mem_cmd_t;

    // Instruction fetches are always full-word reads.
    function automatic mem_cmd_t fetch_cmd(input logic [XLEN-1:0] addr);
        mem_cmd_t cmd;
        cmd.wr_en   = 1'b0;
        cmd.strb    = '1;
        cmd.addr    = addr;
        cmd.wr_data = '0;
        return cmd;
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (MM).
// MM has fixed priority, but IF is forced through after STARVE_MAX consecutive MM grants.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_arb_if_req,
    input  logic [XLEN-1:0] i_arb_if_addr,
    output logic            o_arb_if_ready,
    output logic [XLEN-1:0] o_arb_if_instr,

    input  logic            i_arb_mm_req,
    input  logic            i_arb_mm_wr_en,
    input  logic [3:0]      i_arb_mm_strb,
    input  logic [XLEN-1:0] i_arb_mm_addr,
    input  logic [XLEN-1:0] i_arb_mm_wr_data,
    output logic            o_arb_mm_ready,
    output logic [XLEN-1:0] o_arb_mm_rd_data,

    output logic            o_arb_mem_req,
    output logic            o_arb_mem_wr_en,
    output logic [3:0]      o_arb_mem_strb,
    output logic [XLEN-1:0] o_arb_mem_addr,
    output logic [XLEN-1:0] o_arb_mem_wr_data,
    input  logic [XLEN-1:0] i_arb_mem_rd_data,
    input  logic            i_arb_mem_ack
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

    arb_state_e              state;
    arb_state_e              state_next;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    mem_cmd_t                cmd_q;
    logic                    grant_mm_q;

    logic starve_hit;
    logic pick_mm;
    logic pick_if;

    // Grant decision, only acted upon while IDLE.
    assign starve_hit = i_arb_if_req && (starve_cnt == STARVE_LIMIT);
    assign pick_mm    = i_arb_mm_req && !starve_hit;
    assign pick_if    = i_arb_if_req && !pick_mm;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (pick_mm) begin
                    state_next = ARB_BUSY_MM;
                end else if (pick_if) begin
                    state_next = ARB_BUSY_IF;
                end
            end
            ARB_BUSY_IF,
            ARB_BUSY_MM: begin
                if (i_arb_mem_ack) begin
                    state_next = ARB_DONE;
                end
            end
            ARB_DONE: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // Outputs decode straight from registers, so the memory side sees glitch-free, stable fields.
    always_comb begin
        o_arb_mem_req     = 1'b0;
        o_arb_mem_wr_en   = 1'b0;
        o_arb_mem_strb    = '0;
        o_arb_mem_addr    = '0;
        o_arb_mem_wr_data = '0;
        o_arb_if_ready    = 1'b0;
        o_arb_mm_ready    = 1'b0;
        case (state)
            ARB_BUSY_IF,
            ARB_BUSY_MM: begin
                o_arb_mem_req     = 1'b1;
                o_arb_mem_wr_en   = cmd_q.wr_en;
                o_arb_mem_strb    = cmd_q.strb;
                o_arb_mem_addr    = cmd_q.addr;
                o_arb_mem_wr_data = cmd_q.wr_data;
            end
            ARB_DONE: begin
                o_arb_if_ready = !grant_mm_q;
                o_arb_mm_ready = grant_mm_q;
            end
            default: ;
        endcase
    end

    // NOTE: the command latch has no reset: it is only observed in BUSY/DONE, which a fresh grant always precedes.
    always_ff @(posedge i_clk) begin
        if (state == ARB_IDLE) begin
            if (pick_mm) begin
                cmd_q <= '{wr_en:   i_arb_mm_wr_en,
                           strb:    i_arb_mm_strb,
                           addr:    i_arb_mm_addr,
                           wr_data: i_arb_mm_wr_data};
                grant_mm_q <= 1'b1;
            end else if (pick_if) begin
                cmd_q      <= fetch_cmd(i_arb_if_addr);
                grant_mm_q <= 1'b0;
            end
        end
    end

    // An MM grant with IF waiting cannot happen at the limit, so +1 saturates by construction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_mm && i_arb_if_req) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else if (pick_if) begin
                starve_cnt <= '0;
            end
        end
    end

    // Read data is held for the core between completions; stores never disturb the load result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_arb_if_instr   <= '0;
            o_arb_mm_rd_data <= '0;
        end else if (i_arb_mem_ack) begin
            if (state == ARB_BUSY_IF) begin
                o_arb_if_instr <= i_arb_mem_rd_data;
            end
            if ((state == ARB_BUSY_MM) && !cmd_q.wr_en) begin
                o_arb_mm_rd_data <= i_arb_mem_rd_data;
            end
        end
    end

endmodule
